// File: rtl/mul_seq_ctrl.sv
// Sequential radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, 32 iterations.
// Optional MUL_EARLY_OUT_EN: stop iterating once the remaining multiplier bits are zero.
module mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  alu_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result
);

    // Multiply encodings mirrored from the core's defines.v.
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  op_q,     op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [63:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q,    acc_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] result_q, result_d;

    logic        is_mul;
    logic        signed_a;
    logic        signed_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        can_accept;
    logic        accept;
    logic        last_iter;
    logic        skip_calc;
    logic [63:0] acc_sum;
    logic [63:0] prod;

    assign is_mul   = (alu_op == ALU_MUL) || (alu_op == ALU_MULH) ||
                      (alu_op == ALU_MULHSU) || (alu_op == ALU_MULHU);
    assign signed_a = (alu_op == ALU_MUL) || (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
    assign signed_b = (alu_op == ALU_MUL) || (alu_op == ALU_MULH);

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    assign neg_a = signed_a && operand_a[31];
    assign neg_b = signed_b && operand_b[31];
    assign mag_a = neg_a ? (~operand_a + 32'd1) : operand_a;
    assign mag_b = neg_b ? (~operand_b + 32'd1) : operand_b;

    assign can_accept = (state_q == IDLE) || (state_q == DONE);
    assign accept     = start && is_mul && can_accept;

`ifdef MUL_EARLY_OUT_EN
    assign last_iter = (mplier_q[31:1] == 31'd0) || (cnt_q == 5'd31);
    assign skip_calc = (mag_b == 32'd0);
`else
    assign last_iter = (cnt_q == 5'd31);
    assign skip_calc = 1'b0;
`endif

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign prod    = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (accept) begin
                        op_d     = alu_op;
                        sign_a_d = neg_a;
                        sign_b_d = neg_b;
                        mcand_d  = {32'd0, mag_a};
                        mplier_d = mag_b;
                        acc_d    = 64'd0;
                        cnt_d    = 5'd0;
                        state_d  = skip_calc ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (last_iter) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 4'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy         = (state_q == CALC) || (state_q == FIX);
    assign stall        = !rst && (busy || accept);
    assign result_valid = (state_q == DONE) && !flush;
    assign result       = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: the driver queues expected products and latencies,
// a negedge monitor pops and compares on every result_valid.
module tb_mul_seq_ctrl;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    mul_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .busy         (busy),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        int          base;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    exp_t        mon_e;
    logic [31:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Latency counted with the first cycle after the accepting edge as cycle 1.
    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int n;
        m = ((op == ALU_MUL || op == ALU_MULH) && b[31]) ? (~b + 32'd1) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return 2 + n;
`else
        return (op == ALU_ADD) ? 0 : 34;
`endif
    endfunction

    // Monitor: every result_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            check("valid_gap", prev_valid, 1'b0);
            check("expected_pending", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check({"res_", mon_e.name}, result, mon_e.res);
                check({"lat_", mon_e.name}, cyc - mon_e.base, mon_e.lat);
            end
        end
        prev_valid = result_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        exp_t e;
        start     = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        e.name = name;
        e.res  = exp;
        e.base = cyc;
        e.lat  = exp_lat(op, b);
        sb_q.push_back(e);
        #1;
        check({"stall_acc_", name}, stall, 1'b1);
        @(negedge clk);
        start  = 1'b0;
        alu_op = ALU_ADD;
    endtask

    task automatic wait_idle(input string name, input logic [31:0] exp);
        for (int i = 0; i < 200 && (sb_q.size() != 0 || busy); i++) @(negedge clk);
        check({"drain_", name}, sb_q.size(), 0);
        @(negedge clk);
        check({"hold_", name}, result, exp);
        last_res = exp;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        issue(op, a, b, exp, name);
        wait_idle(name, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        alu_op    = ALU_MUL;
        operand_a = 32'd5;
        operand_b = 32'd6;
        flush     = 1'b0;
        last_res  = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_stall", stall, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // MUL with a start attempted mid-CALC that must be ignored.
        issue(ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        repeat (4) @(negedge clk);
        start     = 1'b1;
        alu_op    = ALU_MULHU;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        #1;
        check("calc_busy", busy, 1'b1);
        check("calc_stall", stall, 1'b1);
        @(negedge clk);
        start  = 1'b0;
        alu_op = ALU_ADD;
        wait_idle("mul_7_m3", 32'hFFFF_FFEB);

        run(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
        run(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run(ALU_MUL,    32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0006, "mul_m2_m3");
        run(ALU_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "mulh_m2_3");
        run(ALU_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, "mulhu_2p31_2");
        run(ALU_MULHSU, 32'h8000_0000, 32'h0000_0004, 32'hFFFF_FFFE, "mulhsu_min_4");
        run(ALU_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, "mulh_max_max");
        run(ALU_MUL,    32'h0000_0005, 32'h0000_0001, 32'h0000_0005, "mul_5_1");
        run(ALU_MUL,    32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "mul_5_0");
        run(ALU_MUL,    32'h0000_0001, 32'h8000_0000, 32'h8000_0000, "mul_1_min");

        // Non-multiply start is ignored.
        start     = 1'b1;
        alu_op    = ALU_ADD;
        operand_a = 32'd3;
        operand_b = 32'd4;
        #1;
        check("nonmul_stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("nonmul_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("nonmul_result", result, last_res);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run(ALU_MUL, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, "mul_1_1");
        issue(ALU_MUL, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, "b2b_first");
        for (int i = 0; i < 100 && !result_valid; i++) @(negedge clk);
        check("b2b_first_seen", result_valid, 1'b1);
        issue(ALU_MUL, 32'h0000_0002, 32'h0000_0005, 32'h0000_000A, "b2b_second");
        wait_idle("b2b_second", 32'h0000_000A);

        // Flush 10 cycles into CALC together with a start.
        issue(ALU_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, "flushed");
        repeat (9) @(negedge clk);
        flush     = 1'b1;
        start     = 1'b1;
        alu_op    = ALU_MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        void'(sb_q.pop_back());
        @(negedge clk);
        flush  = 1'b0;
        start  = 1'b0;
        alu_op = ALU_ADD;
        #1;
        check("flush_busy", busy, 1'b0);
        check("flush_stall", stall, 1'b0);
        check("flush_result", result, last_res);
        repeat (40) @(negedge clk);
        check("flush_result_later", result, last_res);

        // Reset asserted mid-CALC.
        issue(ALU_MUL, 32'h0000_1111, 32'h0000_2222, 32'h0246_8642, "reset_victim");
        repeat (5) @(negedge clk);
        start  = 1'b1;
        alu_op = ALU_MUL;
        rst    = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_result", result, 32'd0);
        check("midrst_stall", stall, 1'b0);
        sb_q.delete();
        @(negedge clk);
        rst    = 1'b0;
        start  = 1'b0;
        alu_op = ALU_ADD;
        repeat (40) @(negedge clk);
        check("postrst_result", result, 32'd0);
        run(ALU_MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, "mul_3_4");

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
